// File: rtl/cache_line_transfer.sv
// cache_line_transfer: drains a victim line to word-serial memory, then fetches and block-writes a fill line.
// Define CACHE_XFER_CRITICAL_WORD_EN to start the fill at the missed word and flag it on word_valid_o.
module cache_line_transfer #(
    parameter int BW_DATA = 32,
    parameter int N_BLOCKS = 128,
    parameter int N_WORDS_PER_BLOCK = 4,
    parameter int BW_TAG_ADDR = 24,
    localparam int BW_ADDR = $clog2(N_BLOCKS),
    localparam int BW_OFFSET = $clog2(N_WORDS_PER_BLOCK),
    localparam int BW_BLOCK = BW_DATA * N_WORDS_PER_BLOCK
) (
    input  logic                           clock_i,
    input  logic                           resetn_i,
    input  logic                           req_i,
    input  logic                           req_wb_i,
    input  logic [BW_TAG_ADDR-1:0]         req_fill_addr_i,
    input  logic [BW_TAG_ADDR-1:0]         req_wb_addr_i,
    input  logic [BW_ADDR-1:0]             req_line_i,
    input  logic [BW_OFFSET-1:0]           req_offset_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [BW_ADDR-1:0]             cache_addr_o,
    output logic                           cache_wren_block_o,
    output logic [BW_BLOCK-1:0]            cache_block_o,
    input  logic [BW_BLOCK-1:0]            cache_block_i,
    output logic                           mem_valid_o,
    output logic                           mem_we_o,
    output logic [BW_TAG_ADDR+BW_OFFSET-1:0] mem_addr_o,
    output logic [BW_DATA-1:0]             mem_data_o,
    input  logic                           mem_ready_i,
    input  logic                           mem_rvalid_i,
    input  logic [BW_DATA-1:0]             mem_data_i,
    output logic                           word_valid_o,
    output logic [BW_DATA-1:0]             word_o
);
    typedef enum logic [2:0] {IDLE, WB_LOAD, WB_SEND, FILL_REQ, FILL_WAIT, FILL_WRITE} state_t;

    state_t                                    state_q, state_d;
    logic [BW_OFFSET-1:0]                      cnt_q, cnt_d;
    logic [N_WORDS_PER_BLOCK-1:0][BW_DATA-1:0] buf_q, buf_d;
    logic [BW_ADDR-1:0]                        line_q, line_d;
    logic [BW_TAG_ADDR-1:0]                    fill_addr_q, fill_addr_d;
    logic [BW_TAG_ADDR-1:0]                    wb_addr_q, wb_addr_d;
    logic [BW_OFFSET-1:0]                      fill_idx;

`ifdef CACHE_XFER_CRITICAL_WORD_EN
    logic [BW_OFFSET-1:0] off_q, off_d;
    // cnt counts words already fetched; the slot rotates from the missed word
    assign fill_idx     = cnt_q + off_q;
    assign word_valid_o = (state_q == FILL_WAIT) && mem_rvalid_i && (cnt_q == '0);
    assign word_o       = word_valid_o ? mem_data_i : '0;
    assign off_d        = (state_q == IDLE && req_i) ? req_offset_i : off_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) off_q <= '0;
        else           off_q <= off_d;
    end
`else
    logic unused_offset;
    assign unused_offset = ^req_offset_i;
    assign fill_idx      = cnt_q;
    assign word_valid_o  = 1'b0;
    assign word_o        = '0;
`endif

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        buf_d              = buf_q;
        line_d             = line_q;
        fill_addr_d        = fill_addr_q;
        wb_addr_d          = wb_addr_q;
        busy_o             = (state_q != IDLE);
        done_o             = 1'b0;
        cache_addr_o       = line_q;
        cache_wren_block_o = 1'b0;
        cache_block_o      = '0;
        mem_valid_o        = 1'b0;
        mem_we_o           = 1'b0;
        mem_addr_o         = '0;
        mem_data_o         = '0;
        case (state_q)
            IDLE: begin
                cache_addr_o = req_i ? req_line_i : '0;
                if (req_i) begin
                    line_d      = req_line_i;
                    fill_addr_d = req_fill_addr_i;
                    wb_addr_d   = req_wb_addr_i;
                    state_d     = req_wb_i ? WB_LOAD : FILL_REQ;
                end
            end
            WB_LOAD: begin
                buf_d   = cache_block_i;
                cnt_d   = '0;
                state_d = WB_SEND;
            end
            WB_SEND: begin
                mem_valid_o = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {wb_addr_q, cnt_q};
                mem_data_o  = buf_q[cnt_q];
                if (mem_ready_i) begin
                    cnt_d   = cnt_q + BW_OFFSET'(1);
                    state_d = (cnt_q == '1) ? FILL_REQ : WB_SEND;
                end
            end
            FILL_REQ: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = {fill_addr_q, fill_idx};
                state_d     = mem_ready_i ? FILL_WAIT : FILL_REQ;
            end
            FILL_WAIT: begin
                if (mem_rvalid_i) begin
                    buf_d[fill_idx] = mem_data_i;
                    cnt_d           = cnt_q + BW_OFFSET'(1);
                    state_d         = (cnt_q == '1) ? FILL_WRITE : FILL_REQ;
                end
            end
            FILL_WRITE: begin
                cache_wren_block_o = 1'b1;
                cache_block_o      = buf_q;
                done_o             = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            buf_q       <= '0;
            line_q      <= '0;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            line_q      <= line_d;
            fill_addr_q <= fill_addr_d;
            wb_addr_q   <= wb_addr_d;
        end
    end
endmodule

// File: doc/cache_line_transfer.md
Name: cache_line_transfer

Overview:
- Line-transfer engine on the far side of the cache data array's block port.
- Drains a victim line from the array word-by-word to main memory (writeback), then fetches a line word-by-word from main memory and installs it in the array with a single block write (fill).
- Sits between the cache controller, the data array and the word-serial main-memory port.

Parameters:
- BW_DATA, 32, word width in bits.
- N_BLOCKS, 128, cache lines in the array; BW_ADDR = CLOG2(N_BLOCKS).
- N_WORDS_PER_BLOCK, 4, words per line (power of 2, >=2); BW_OFFSET = CLOG2(N_WORDS_PER_BLOCK).
- BW_TAG_ADDR, 24, main-memory line address width; main-memory word address = {line address, offset}.

Ports:
- clock_i  in  1  clock, rising edge.
- resetn_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  start a transfer; sampled only in IDLE.
- req_wb_i  in  1  1 = writeback victim before fill.
- req_fill_addr_i  in  BW_TAG_ADDR  line address to fetch.
- req_wb_addr_i  in  BW_TAG_ADDR  line address of the victim.
- req_line_i  in  BW_ADDR  cache line index.
- req_offset_i  in  BW_OFFSET  missed word offset; used only by the optional feature.
- busy_o  out  1  high from request acceptance until done_o.
- done_o  out  1  one-cycle pulse when the fill write is issued.
- cache_addr_o  out  BW_ADDR  line index to the array.
- cache_wren_block_o  out  1  block write strobe.
- cache_block_o  out  BW_DATA*N_WORDS_PER_BLOCK  fill line to the array.
- cache_block_i  in  BW_DATA*N_WORDS_PER_BLOCK  array read data; valid one cycle after cache_addr_o.
- mem_valid_o  out  1  word request valid.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  BW_TAG_ADDR+BW_OFFSET  word address.
- mem_data_o  out  BW_DATA  write data.
- mem_ready_i  in  1  request accepted when valid & ready.
- mem_rvalid_i  in  1  read data valid.
- mem_data_i  in  BW_DATA  read data.
- word_valid_o  out  1  optional-feature output; tie 0 when the feature is compiled out.
- word_o  out  BW_DATA  optional-feature output; tie 0 when the feature is compiled out.

Behaviour:
- Reset: state IDLE; all outputs, counters and the line buffer clear to 0.
- IDLE:
  - When req_i = 1, latch all req_* inputs, set busy_o = 1 the next cycle, and drive cache_addr_o = req_line_i.
  - Next state: WB_LOAD if req_wb_i = 1, else FILL_REQ.
- WB_LOAD (1 cycle): capture cache_block_i into the line buffer; counter = 0; go to WB_SEND.
- WB_SEND:
  - Drive mem_valid_o = 1, mem_we_o = 1, mem_addr_o = {wb_addr, cnt}, mem_data_o = buffer word cnt.
  - Hold all request signals stable until mem_ready_i = 1.
  - On the accepted handshake, cnt++. After the last word: cnt wraps to 0, go to FILL_REQ.
- FILL_REQ: drive mem_valid_o = 1, mem_we_o = 0, mem_addr_o = {fill_addr, cnt}; on the handshake go to FILL_WAIT.
- FILL_WAIT:
  - mem_valid_o = 0.
  - On mem_rvalid_i = 1, store mem_data_i into buffer word cnt and cnt++.
  - Go to FILL_WRITE after the last word, else back to FILL_REQ.
  - At most one read is outstanding.
- FILL_WRITE (1 cycle): cache_wren_block_o = 1, cache_addr_o = latched line, cache_block_o = buffer (word 0 in the low bits); done_o = 1; go to IDLE with busy_o = 0.
- mem_rvalid_i outside FILL_WAIT is ignored. mem_ready_i while mem_valid_o = 0 is ignored.
- Minimum latency, with ready and rvalid arriving immediately:
  - Fill only: 2*N_WORDS_PER_BLOCK + 2 cycles from req_i to done_o.
  - Writeback + fill: 3*N_WORDS_PER_BLOCK + 3 cycles.
- req_i while busy_o = 1 is ignored; there is no queueing.
- Reset asserted mid-transfer aborts immediately: no block write occurs and mem_valid_o drops asynchronously.

Optional Feature:
- Macro: CACHE_XFER_CRITICAL_WORD_EN.
- Enabled:
  - Fill word order starts at the latched req_offset_i and wraps modulo N_WORDS_PER_BLOCK. Writeback order is unchanged (0 first).
  - On the cycle the first fill word is stored, word_valid_o pulses for 1 cycle with word_o = mem_data_i.
- Disabled: fill order is always 0..N-1; word_valid_o and word_o are tied to 0.

Test Plan:
- Fill only, N=4, fill_addr=0x000010, line=5, ready/rvalid immediate -> read addresses 0x40..0x43; one block write to line 5 with words {D0..D3}; done_o pulses at cycle 10.
- Writeback+fill, array line 2 = {A,B,C,D}, wb_addr=0x000020 -> writes 0x80=A, 0x81=B, 0x82=C, 0x83=D, then reads 0x40..0x43, then the block write; done_o at cycle 15.
- mem_ready_i low for 3 cycles on writeback word 1 -> mem_addr_o, mem_data_o and mem_we_o held stable throughout; no word skipped or repeated.
- req_i pulsed while busy_o = 1 -> ignored; exactly one done_o.
- resetn_i low during FILL_WAIT -> outputs 0 at once; no cache_wren_block_o; the next request completes normally.
- With CACHE_XFER_CRITICAL_WORD_EN and req_offset_i=2 -> read order 2,3,0,1; word_valid_o pulses with word 2's data; the block write still places each word in its correct slot.
